mem_stage: RTL and testbench
============================

# mem_stage

M-stage datapath block of the five-stage MIPS pipeline. Consumes the E/M pipeline register contents (instruction, PC+4, ALU result, store data, exception code). Performs data-memory loads and stores with byte/halfword sizing and address-error detection, then registers results into the M/W pipeline register. Contains the data memory array and the M-stage forwarding mux for store data.

## Interface
- `DM_WORDS`, 4096: data memory depth in 32-bit words. Valid byte addresses are 0 .. `DM_WORDS*4-1`.
- `Clk  in  1`: pipeline clock. All state updates on the rising edge.
- `Reset  in  1`: synchronous, active-high.
- `IRM  in  32`: instruction in M.
- `PC4M  in  32`: PC+4 of that instruction.
- `AOM  in  32`: ALU result, used as the effective byte address for loads and stores.
- `RTM  in  32`: store data as registered from E.
- `ExcCodeM  in  [6:2]`: exception code carried from E.
- `Forward_RT_M_Sel  in  1`: selects store data. 0 = `RTM`; 1 = `MUX_RF_WD_OUT`.
- `MUX_RF_WD_OUT  in  32`: W-stage register-file write data, used for forwarding.
- `exp_in  in  1`: exception/flush being taken this cycle.
- `IRW  out  32`, `PC4W  out  32`, `AOW  out  32`: registered pass-through of `IRM`, `PC4M`, `AOM`.
- `DRW  out  32`: registered, already sign/zero-extended load data. 0 for non-loads.
- `ExcCodeW  out  [6:2]`: registered exception code.
- `BadVAddrW  out  32`: registered faulting address. 0 when there is no M-stage address error.

## Operation
- Opcode decode on `IRM[31:26]`:
  - Loads: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24.
  - Stores: sw 0x2B, sh 0x29, sb 0x28.
  - Any other opcode is a non-memory instruction.
- Store data `SD` = `Forward_RT_M_Sel ? MUX_RF_WD_OUT : RTM`.
- Address error. `AOM` is misaligned or out of range when:
  - word access: `AOM[1:0]!=0`;
  - halfword access: `AOM[0]!=0`;
  - any access: `AOM >= DM_WORDS*4`.
  - A load error gives AdEL (4); a store error gives AdES (5).
- Exception priority:
  - If `ExcCodeM` != `ExcCode_default`, it passes unchanged and no M check applies (`BadVAddrW`=0).
  - Otherwise an AdEL/AdES result is emitted, with `BadVAddrW`=`AOM`.
  - Otherwise `ExcCode_default`.
- Store commit happens at the edge only when all of these hold: store opcode, no M or incoming exception, `exp_in`=0, `Reset`=0.
- Store byte enables, word index `AOM[13:2]` (width log2(DM_WORDS)):
  - sw: `BE`=1111, whole word.
  - sh: `BE`=0011 (`AOM[1]`=0) or 1100, with `SD[15:0]` replicated into both halves.
  - sb: `BE`=`1<<AOM[1:0]`, with `SD[7:0]` replicated into all four bytes.
- Load read is combinational from the array. Lane select is by `AOM[1:0]`, then extension:
  - lb/lh: sign-extend.
  - lbu/lhu: zero-extend.
  - lw: whole word.
  - A faulting load registers `DRW`=0.
- Memory contents are 0 at time zero and are not cleared by `Reset`.

## Timing
- One-cycle latency from M inputs to W outputs.
- Reset (highest priority) and `exp_in` both clear registers at the edge:
  - `IRW`, `PC4W`, `AOW`, `DRW`, `BadVAddrW` = 0.
  - `ExcCodeW` = `ExcCode_default`.
  - No memory write occurs.
- Reset asserted mid-stream: a store present in M that cycle is discarded.
- Write-then-read: a store committed at edge N is visible to a load in M during cycle N+1.
- A load and a store never coexist in M. Byte lanes not enabled by `BE` keep their prior value.
- Out-of-range addresses never index the array.

## Structure
- Opcode and field macros go in `header_ind.v`. `ExcCode_default`, AdEL=4 and AdES=5 go in `header_expint.v`.
- Sub-module `dm`:
  - ports: `Clk`, `WE`, `BE[3:0]`, word address, `WD[31:0]`, `RD[31:0]` (async read);
  - one instance, parameterised by `DM_WORDS`.
- Top level holds the decode, the forwarding mux, the exception logic, load extension and the M/W register.

## Test plan
- sw `AOM`=0x10, `RTM`=0xDEADBEEF, then lw 0x10 → `DRW`=0xDEADBEEF one cycle after the lw, `ExcCodeW`=default.
- sb `AOM`=0x13, `SD`=0x80, then lb 0x13 → `DRW`=0xFFFFFF80; lbu 0x13 → `DRW`=0x00000080; word at 0x10 = 0x80ADBEEF.
- sh `AOM`=0x22 with `Forward_RT_M_Sel`=1, `MUX_RF_WD_OUT`=0x1234ABCD → word at 0x20 upper half = 0xABCD, lower half unchanged.
- lw `AOM`=0x6 → `ExcCodeW`=4, `BadVAddrW`=0x6, `DRW`=0.
- sw `AOM`=0x4000 (DM_WORDS=4096) → `ExcCodeW`=5, memory unchanged.
- sw with `exp_in`=1 → no write; all W outputs 0/default.
- Sequence with `Reset`=1 → no write; all W outputs 0/default.
- Incoming `ExcCodeM`=10 on a misaligned sw → `ExcCodeW`=10, `BadVAddrW`=0, no write.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared opcode, exception-code and pipeline-register definitions for the M stage.
package mem_stage_pkg;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  localparam logic [4:0] EXC_DEFAULT = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;

  typedef enum logic [3:0] {
    MOP_NONE, MOP_LW, MOP_LH, MOP_LHU, MOP_LB, MOP_LBU, MOP_SW, MOP_SH, MOP_SB
  } mem_op_e;

  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc4;
    logic [31:0] ao;
    logic [31:0] dr;
    logic [4:0]  exc;
    logic [31:0] bad_vaddr;
  } mw_reg_t;

  localparam mw_reg_t MW_CLEAR = '{exc: EXC_DEFAULT, default: '0};

  function automatic mem_op_e decode_op(input logic [5:0] opcode);
    case (opcode)
      OP_LW:   return MOP_LW;
      OP_LH:   return MOP_LH;
      OP_LHU:  return MOP_LHU;
      OP_LB:   return MOP_LB;
      OP_LBU:  return MOP_LBU;
      OP_SW:   return MOP_SW;
      OP_SH:   return MOP_SH;
      OP_SB:   return MOP_SB;
      default: return MOP_NONE;
    endcase
  endfunction

  function automatic mem_size_e op_size(input mem_op_e op);
    case (op)
      MOP_LW, MOP_SW:          return SZ_WORD;
      MOP_LH, MOP_LHU, MOP_SH: return SZ_HALF;
      MOP_LB, MOP_LBU, MOP_SB: return SZ_BYTE;
      default:                 return SZ_NONE;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == MOP_SW) || (op == MOP_SH) || (op == MOP_SB);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// E/M inputs and M/W outputs of the memory stage, bundled as one bus.
interface mem_stage_if;
  logic [31:0] IRM;
  logic [31:0] PC4M;
  logic [31:0] AOM;
  logic [31:0] RTM;
  logic [6:2]  ExcCodeM;
  logic        Forward_RT_M_Sel;
  logic [31:0] MUX_RF_WD_OUT;
  logic        exp_in;

  logic [31:0] IRW;
  logic [31:0] PC4W;
  logic [31:0] AOW;
  logic [31:0] DRW;
  logic [6:2]  ExcCodeW;
  logic [31:0] BadVAddrW;

  modport master (
    output IRM, PC4M, AOM, RTM, ExcCodeM, Forward_RT_M_Sel, MUX_RF_WD_OUT, exp_in,
    input  IRW, PC4W, AOW, DRW, ExcCodeW, BadVAddrW
  );

  modport slave (
    input  IRM, PC4M, AOM, RTM, ExcCodeM, Forward_RT_M_Sel, MUX_RF_WD_OUT, exp_in,
    output IRW, PC4W, AOW, DRW, ExcCodeW, BadVAddrW
  );
endinterface

// File: rtl/mem_stage_dm.sv
// Data memory: byte-enabled synchronous write, asynchronous word read.
module dm #(
  parameter int DM_WORDS = 4096,
  localparam int AW = $clog2(DM_WORDS)
) (
  input  logic          Clk,
  input  logic          WE,
  input  logic [3:0]    BE,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   WD,
  output logic [31:0]   RD
);

  // NOTE: the array gets a power-up value but no reset; clearing thousands of words
  // on Reset would force flops instead of RAM and contradicts contents surviving reset.
  logic [31:0] mem [DM_WORDS] = '{default: '0};

  always_ff @(posedge Clk) begin
    if (WE) begin
      for (int b = 0; b < 4; b++) begin
        if (BE[b]) mem[addr][8*b +: 8] <= WD[8*b +: 8];
      end
    end
  end

  assign RD = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS M stage: store-data forwarding, address checks, load extension and M/W register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DM_WORDS = 4096
) (
  input logic       Clk,
  input logic       Reset,
  mem_stage_if.slave bus
);

  localparam int          AW       = $clog2(DM_WORDS);
  localparam logic [31:0] DM_BYTES = 32'(DM_WORDS * 4);

  mem_op_e       op;
  mem_size_e     size;
  logic [31:0]   sd;
  logic          out_of_range;
  logic          addr_err;
  logic          exc_in;
  logic          dm_we;
  logic [3:0]    dm_be;
  logic [31:0]   dm_wd;
  logic [31:0]   dm_rd;
  logic [AW-1:0] dm_addr;
  logic [31:0]   lane;
  mw_reg_t       mw_d;
  mw_reg_t       mw_q;

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    op           = decode_op(bus.IRM[31:26]);
    size         = op_size(op);
    sd           = bus.Forward_RT_M_Sel ? bus.MUX_RF_WD_OUT : bus.RTM;
    out_of_range = bus.AOM >= DM_BYTES;
    exc_in       = bus.ExcCodeM != EXC_DEFAULT;
    addr_err     = (size != SZ_NONE) &&
                   (out_of_range ||
                    (size == SZ_WORD && bus.AOM[1:0] != 2'b00) ||
                    (size == SZ_HALF && bus.AOM[0]));
    // Faulting addresses are steered to word 0 so the array is never indexed out of range.
    dm_addr      = out_of_range ? '0 : bus.AOM[AW+1:2];
    dm_we        = is_store(op) && !exc_in && !addr_err && !bus.exp_in && !Reset;

    dm_be = 4'b0000;
    dm_wd = sd;
    case (op)
      MOP_SW: dm_be = 4'b1111;
      MOP_SH: begin
        dm_be = bus.AOM[1] ? 4'b1100 : 4'b0011;
        dm_wd = {2{sd[15:0]}};
      end
      MOP_SB: begin
        dm_be = 4'b0001 << bus.AOM[1:0];
        dm_wd = {4{sd[7:0]}};
      end
      default: ;
    endcase

    lane = dm_rd >> {bus.AOM[1:0], 3'b000};

    mw_d           = MW_CLEAR;
    mw_d.ir        = bus.IRM;
    mw_d.pc4       = bus.PC4M;
    mw_d.ao        = bus.AOM;
    if (exc_in) begin
      mw_d.exc = bus.ExcCodeM;
    end else if (addr_err) begin
      mw_d.exc       = is_store(op) ? EXC_ADES : EXC_ADEL;
      mw_d.bad_vaddr = bus.AOM;
    end

    if (!exc_in && !addr_err) begin
      case (op)
        MOP_LW:  mw_d.dr = dm_rd;
        MOP_LH:  mw_d.dr = {{16{lane[15]}}, lane[15:0]};
        MOP_LHU: mw_d.dr = {16'h0000, lane[15:0]};
        MOP_LB:  mw_d.dr = {{24{lane[7]}}, lane[7:0]};
        MOP_LBU: mw_d.dr = {24'h000000, lane[7:0]};
        default: mw_d.dr = '0;
      endcase
    end
  end

  dm #(.DM_WORDS(DM_WORDS)) u_dm (
    .Clk  (Clk),
    .WE   (dm_we),
    .BE   (dm_be),
    .addr (dm_addr),
    .WD   (dm_wd),
    .RD   (dm_rd)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clk) begin
    if (Reset || bus.exp_in) mw_q <= MW_CLEAR;
    else                     mw_q <= mw_d;
  end

  assign bus.IRW       = mw_q.ir;
  assign bus.PC4W      = mw_q.pc4;
  assign bus.AOW       = mw_q.ao;
  assign bus.DRW       = mw_q.dr;
  assign bus.ExcCodeW  = mw_q.exc;
  assign bus.BadVAddrW = mw_q.bad_vaddr;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads/stores, sizing, address errors, flush and reset.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   fails;

  logic [31:0] exp_ir;
  logic [31:0] exp_pc4;
  logic [31:0] exp_ao;
  logic [31:0] pc;

  mem_stage_if bus ();

  mem_stage #(.DM_WORDS(4096)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drives one instruction into M for one cycle and samples W outputs 1 time unit after the edge.
  task automatic apply(input logic [5:0] op, input logic [31:0] aom, input logic [31:0] rtm,
                       input logic fwd = 1'b0, input logic [31:0] wdout = 32'h0,
                       input logic [4:0] exc = EXC_DEFAULT, input logic flush = 1'b0,
                       input logic rst = 1'b0);
    pc                   = pc + 32'd4;
    exp_ir               = {op, 26'h1234567};
    exp_pc4              = pc;
    exp_ao               = aom;
    bus.IRM              = exp_ir;
    bus.PC4M             = exp_pc4;
    bus.AOM              = aom;
    bus.RTM              = rtm;
    bus.Forward_RT_M_Sel = fwd;
    bus.MUX_RF_WD_OUT    = wdout;
    bus.ExcCodeM         = exc;
    bus.exp_in           = flush;
    reset                = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_w(input string tag, input logic [31:0] dr,
                          input logic [4:0] exc, input logic [31:0] bad);
    check({tag, ".IRW"}, bus.IRW, exp_ir);
    check({tag, ".PC4W"}, bus.PC4W, exp_pc4);
    check({tag, ".AOW"}, bus.AOW, exp_ao);
    check({tag, ".DRW"}, bus.DRW, dr);
    check({tag, ".ExcCodeW"}, 32'(bus.ExcCodeW), 32'(exc));
    check({tag, ".BadVAddrW"}, bus.BadVAddrW, bad);
  endtask

  task automatic expect_clear(input string tag);
    check({tag, ".IRW"}, bus.IRW, 32'h0);
    check({tag, ".PC4W"}, bus.PC4W, 32'h0);
    check({tag, ".AOW"}, bus.AOW, 32'h0);
    check({tag, ".DRW"}, bus.DRW, 32'h0);
    check({tag, ".ExcCodeW"}, 32'(bus.ExcCodeW), 32'(EXC_DEFAULT));
    check({tag, ".BadVAddrW"}, bus.BadVAddrW, 32'h0);
  endtask

  task automatic expect_dr(input string tag, input logic [31:0] dr);
    check({tag, ".DRW"}, bus.DRW, dr);
    check({tag, ".ExcCodeW"}, 32'(bus.ExcCodeW), 32'(EXC_DEFAULT));
  endtask

  initial begin
    total = 0;
    fails = 0;
    pc    = 32'h0040_3000;

    // Store presented while in reset must be discarded; outputs held at cleared values.
    apply(OP_SW, 32'h10, 32'h1111_1111, .rst(1'b1));
    expect_clear("reset_init");
    apply(OP_LW, 32'h10, 32'h0);
    expect_w("lw_after_reset", 32'h0, EXC_DEFAULT, 32'h0);

    // Word store then load.
    apply(OP_SW, 32'h10, 32'hDEAD_BEEF);
    expect_w("sw_10", 32'h0, EXC_DEFAULT, 32'h0);
    apply(OP_LW, 32'h10, 32'h0);
    expect_w("lw_10", 32'hDEAD_BEEF, EXC_DEFAULT, 32'h0);

    // Byte store into lane 3, only SD[7:0] used.
    apply(OP_SB, 32'h13, 32'h1234_5680);
    expect_w("sb_13", 32'h0, EXC_DEFAULT, 32'h0);
    apply(OP_LB, 32'h13, 32'h0);
    expect_dr("lb_13", 32'hFFFF_FF80);
    apply(OP_LBU, 32'h13, 32'h0);
    expect_dr("lbu_13", 32'h0000_0080);
    apply(OP_LW, 32'h10, 32'h0);
    expect_dr("lw_10_after_sb", 32'h80AD_BEEF);

    // Halfword store with forwarded data into the upper half.
    apply(OP_SW, 32'h20, 32'h5566_7788);
    apply(OP_SH, 32'h22, 32'hFFFF_FFFF, .fwd(1'b1), .wdout(32'h1234_ABCD));
    expect_w("sh_22_fwd", 32'h0, EXC_DEFAULT, 32'h0);
    apply(OP_LW, 32'h20, 32'h0);
    expect_dr("lw_20", 32'hABCD_7788);
    apply(OP_LH, 32'h22, 32'h0);
    expect_dr("lh_22", 32'hFFFF_ABCD);
    apply(OP_LHU, 32'h20, 32'h0);
    expect_dr("lhu_20", 32'h0000_7788);
    apply(OP_LB, 32'h21, 32'h0);
    expect_dr("lb_21", 32'h0000_0077);
    apply(OP_LBU, 32'h22, 32'h0);
    expect_dr("lbu_22", 32'h0000_00CD);

    // Load address errors.
    apply(OP_LW, 32'h6, 32'h0);
    expect_w("lw_misalign_6", 32'h0, EXC_ADEL, 32'h6);
    apply(OP_LW, 32'h12, 32'h0);
    expect_w("lw_misalign_12", 32'h0, EXC_ADEL, 32'h12);
    apply(OP_LH, 32'h11, 32'h0);
    expect_w("lh_misalign_11", 32'h0, EXC_ADEL, 32'h11);
    apply(OP_LBU, 32'h4000, 32'h0);
    expect_w("lbu_oor_4000", 32'h0, EXC_ADEL, 32'h4000);

    // Store address errors leave memory untouched.
    apply(OP_SW, 32'h4000, 32'hBAD0_BAD0);
    expect_w("sw_oor_4000", 32'h0, EXC_ADES, 32'h4000);
    apply(OP_LW, 32'h0, 32'h0);
    expect_dr("lw_0_unchanged", 32'h0);
    apply(OP_SH, 32'h21, 32'hFFFF_FFFF);
    expect_w("sh_misalign_21", 32'h0, EXC_ADES, 32'h21);
    apply(OP_LW, 32'h20, 32'h0);
    expect_dr("lw_20_unchanged", 32'hABCD_7788);

    // Last word of the array.
    apply(OP_SW, 32'h3FFC, 32'hA5A5_0001);
    expect_w("sw_last", 32'h0, EXC_DEFAULT, 32'h0);
    apply(OP_LW, 32'h3FFC, 32'h0);
    expect_dr("lw_last", 32'hA5A5_0001);
    apply(OP_LB, 32'h3FFF, 32'h0);
    expect_dr("lb_last_byte", 32'hFFFF_FFA5);

    // Flush suppresses the write and clears W.
    apply(OP_SW, 32'h10, 32'hCAFE_F00D, .flush(1'b1));
    expect_clear("sw_flush");
    apply(OP_LW, 32'h10, 32'h0);
    expect_dr("lw_10_after_flush", 32'h80AD_BEEF);

    // Incoming exception overrides the M check and blocks the store.
    apply(OP_SW, 32'h11, 32'h7777_7777, .exc(5'd10));
    expect_w("sw_misalign_excin", 32'h0, 5'd10, 32'h0);
    apply(OP_SW, 32'h10, 32'h6666_6666, .exc(5'd10));
    expect_w("sw_aligned_excin", 32'h0, 5'd10, 32'h0);
    apply(OP_LW, 32'h10, 32'h0);
    expect_dr("lw_10_after_excin", 32'h80AD_BEEF);

    // Non-memory instruction with an odd ALU result is not an address error.
    apply(6'h00, 32'h3, 32'hFFFF_FFFF);
    expect_w("alu_op", 32'h0, EXC_DEFAULT, 32'h0);

    // Reset mid-stream discards the store in M.
    apply(OP_SW, 32'h10, 32'h9999_9999, .rst(1'b1));
    expect_clear("sw_reset_mid");
    apply(OP_LW, 32'h10, 32'h0);
    expect_w("lw_10_after_reset", 32'h80AD_BEEF, EXC_DEFAULT, 32'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
